lfsr_seq_ctrl: RTL
==================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter TAPS, default 8'h1D, is the Galois feedback mask (x^8+x^4+x^3+x^2+1, maximal length, period 255).
REQ-002 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1, asynchronous active-high reset.
REQ-004 Port start, input, 1, request to begin a burst; sampled only in IDLE.
REQ-005 Port seed, input, 8, initial LFSR state; captured with start.
REQ-006 Port count, input, 8, number of words in the burst; 0 means 256; captured with start.
REQ-007 Port abort, input, 1, terminates a burst in progress.
REQ-008 Port out_data, output, 8, current LFSR word.
REQ-009 Port out_valid, output, 1, out_data holds a word to be taken.
REQ-010 Port out_ready, input, 1, consumer accepts the word when out_valid is high.
REQ-011 Port busy, output, 1, high in every state except IDLE.
REQ-012 Port done, output, 1, one-cycle pulse after the last word of a burst is accepted.
REQ-013 Port seed_fix, output, 1, sticky flag, set when a zero seed was replaced; cleared by the next accepted start.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE with start=1: capture seed and count, load LFSR, go to RUN on the next cycle.
REQ-016 A captured seed of 8'h00 SHALL be replaced by 8'h01 and SHALL set seed_fix.
REQ-017 LFSR step SHALL be next[0]=s[7]; next[k]=s[k-1]^(TAPS[k]&s[7]) for k=1..7.
REQ-018 In RUN, out_valid=1 and out_data=current LFSR state.
REQ-019 A transfer occurs when out_valid&&out_ready; the LFSR then steps once and the remaining count decrements once.
REQ-020 While out_valid&&!out_ready, out_data and the LFSR SHALL hold stable.
REQ-021 The first word SHALL equal the seed (after zero fix); latency from start to out_valid is 1 cycle.
REQ-022 Transfer of the last word: go to DONE; out_valid=0 in DONE; done=1 for exactly that cycle; then return to IDLE.
REQ-023 A count of 0 SHALL yield 256 transfers; the remaining counter is 9 bits wide, with no wrap before completion.
REQ-024 abort=1 in RUN: go to IDLE next cycle, with no transfer in that cycle even if out_ready=1, and no done pulse.
REQ-025 abort in IDLE or DONE SHALL be ignored.
REQ-026 start while busy SHALL be ignored; it is not queued.
REQ-027 abort and start both high in IDLE: start wins.

Reset
REQ-028 rst=1 SHALL force IDLE immediately, asynchronously, from any state, including mid-burst.
REQ-029 Reset values: out_valid=0, out_data=8'h00, busy=0, done=0, seed_fix=0, LFSR=8'h00, counter=0.
REQ-030 A burst interrupted by reset SHALL NOT resume and SHALL NOT pulse done.

Structure
REQ-031 The shared package lfsr_pkg SHALL hold the state enum (IDLE/RUN/DONE), LFSR_W=8, the TAPS default 8'h1D, and the zero-seed replacement 8'h01.
REQ-032 The shift register SHALL be the sub-module lfsr8_core (inputs: load, load_val, step; output: state; same clk/rst).
REQ-033 The FSM and counter SHALL reside in lfsr_seq_ctrl.

Verification
REQ-034 seed=8'h01, count=9, out_ready=1 held -> words 01,02,04,08,10,20,40,80,1D, then done pulse, busy=0.
REQ-035 seed=8'h00, count=2 -> seed_fix=1; words 01,02.
REQ-036 seed=8'h01, count=4, out_ready toggled 1/0 per cycle -> word held during ready=0 cycles; 4 transfers exactly; done after 4th.
REQ-037 count=0, seed=8'hA5 -> 256 transfers; word 256 equals word 1 (period 255).
REQ-038 count=10, abort asserted after 3 transfers with out_ready=1 -> exactly 3 transfers, no done, IDLE next cycle; start during burst ignored.
REQ-039 rst pulsed mid-burst between clock edges -> outputs at reset values before the next edge; no done pulse.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR burst sequencer.
// State encoding, widths, tap default and zero-seed substitute.
package lfsr_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] TAPS_DEF = 8'h1D;
    localparam logic [LFSR_W-1:0] SEED_SUB = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Galois step: rotate left, xor taps into bits 7..1 when the msb falls out
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] taps
    );
        logic [LFSR_W-1:0] rot;
        logic [LFSR_W-1:0] mask;
        rot  = {s[LFSR_W-2:0], s[LFSR_W-1]};
        mask = {taps[LFSR_W-1:1], 1'b0};
        return rot ^ (mask & {LFSR_W{s[LFSR_W-1]}});
    endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Galois LFSR register with synchronous load and step.
// Load takes priority over step; state holds otherwise.
module lfsr8_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS = TAPS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    // shift register: load a new seed or advance one step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= lfsr_step(state, TAPS);
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Burst controller streaming LFSR words over a valid/ready port.
// Holds the FSM, the 9-bit remaining-word counter and the seed flag.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS = TAPS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LFSR_W-1:0] count,
    input  logic              abort,
    output logic [LFSR_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              seed_fix
);

    state_t            state_q;
    state_t            state_d;
    logic [LFSR_W:0]   cnt_q;
    logic              load;
    logic              step;
    logic              seed_zero;
    logic [LFSR_W-1:0] load_val;
    logic [LFSR_W-1:0] lfsr_q;

    assign seed_zero = (seed == '0);
    assign load_val  = seed_zero ? SEED_SUB : seed;

    lfsr8_core #(
        .TAPS(TAPS)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .step    (step),
        .state   (lfsr_q)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, load and step decisions; abort beats a transfer in RUN
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    step = 1'b1;
                    if (cnt_q == 9'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // remaining words; a count of zero loads 256
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= {(count == '0), count};
        end else if (step) begin
            cnt_q <= cnt_q - 9'd1;
        end
    end

    // sticky zero-seed flag, rewritten by every accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_fix <= 1'b0;
        end else if (load) begin
            seed_fix <= seed_zero;
        end
    end

    assign out_data  = lfsr_q;
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
